mem_bus_arbiter: RTL and testbench

- Shares the single Mem_top bus port (addr / data / req_valid / data_valid / WE) between two requesters: port 0 = instruction fetch, port 1 = load/store.
- Fair round-robin grant, one outstanding transaction at a time.
- Registered memory-side request; response returned to the owning requester with an error flag on timeout.
- Sits in SOC between cpu_top's fetch/LSU units and Mem_top.

---
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus port between
// instruction fetch (port 0) and load/store (port 1).
module mem_bus_arbiter #(
    parameter int unsigned MEM_DEPTH  = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic                  r0_we,
    output logic                  r0_gnt,
    output logic                  r0_done,
    input  logic                  r1_req,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic                  r1_we,
    output logic                  r1_gnt,
    output logic                  r1_done,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  req_valid,
    output logic                  we,
    input  logic                  data_valid,
    output logic                  busy
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  we_d;
    logic                  req_valid_d;
    logic                  busy_d;
    logic                  r0_done_d, r1_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_err_d;
    logic                  any_req_c;
    logic                  win_c;

    // Round-robin pick: a lone requester wins, a tie goes to the port that did not win last
    always_comb begin
        any_req_c = r0_req | r1_req;
        win_c     = r1_req & (~r0_req | ~last_q);
    end

    // Grant pulses in the arbitration cycle; gated so they stay low while reset is held
    assign r0_gnt = reset & (state_q == IDLE) & any_req_c & ~win_c;
    assign r1_gnt = reset & (state_q == IDLE) & any_req_c &  win_c;

    // Next-state and next-value logic for the FSM and its registered outputs
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        addr_d      = addr;
        wdata_d     = wdata;
        we_d        = we;
        req_valid_d = req_valid;
        busy_d      = busy;
        r0_done_d   = 1'b0;
        r1_done_d   = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d     = BUSY;
                    owner_d     = win_c;
                    last_d      = win_c;
                    addr_d      = win_c ? r1_addr  : r0_addr;
                    wdata_d     = win_c ? r1_wdata : r0_wdata;
                    we_d        = win_c ? r1_we    : r0_we;
                    cnt_d       = '0;
                    req_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                // A completion arriving on the timeout cycle still counts as a success
                if (data_valid) begin
                    state_d     = RESP;
                    req_valid_d = 1'b0;
                    rsp_rdata_d = we ? '0 : rdata;
                    rsp_err_d   = 1'b0;
                    r0_done_d   = ~owner_q;
                    r1_done_d   = owner_q;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    req_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    r0_done_d   = ~owner_q;
                    r1_done_d   = owner_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                req_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            addr      <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            req_valid <= 1'b0;
            busy      <= 1'b0;
            r0_done   <= 1'b0;
            r1_done   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            addr      <= addr_d;
            wdata     <= wdata_d;
            we        <= we_d;
            req_valid <= req_valid_d;
            busy      <= busy_d;
            r0_done   <= r0_done_d;
            r1_done   <= r1_done_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_mem_bus_arbiter;

    localparam int unsigned MEM_DEPTH  = 8;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned AW         = $clog2(MEM_DEPTH);

    logic                  clk;
    logic                  reset;
    logic                  r0_req, r1_req;
    logic [AW-1:0]         r0_addr, r1_addr;
    logic [DATA_WIDTH-1:0] r0_wdata, r1_wdata;
    logic                  r0_we, r1_we;
    logic                  r0_gnt, r1_gnt, r0_done, r1_done;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  req_valid, we, data_valid, busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                    m_last;
    bit                    exp_owner;
    logic [AW-1:0]         exp_addr;
    logic [DATA_WIDTH-1:0] exp_wdata;
    logic                  exp_we;
    logic [DATA_WIDTH-1:0] exp_rsp;
    logic                  exp_err;
    logic [DATA_WIDTH-1:0] forced_rdata;
    bit                    use_forced;

    mem_bus_arbiter #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (r0_req),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_we     (r0_we),
        .r0_gnt    (r0_gnt),
        .r0_done   (r0_done),
        .r1_req    (r1_req),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_we     (r1_we),
        .r1_gnt    (r1_gnt),
        .r1_done   (r1_done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .req_valid (req_valid),
        .we        (we),
        .data_valid(data_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input bit q0, input bit q1);
        r0_req     = q0;
        r1_req     = q1;
        r0_addr    = AW'($urandom_range(0, MEM_DEPTH - 1));
        r1_addr    = AW'($urandom_range(0, MEM_DEPTH - 1));
        r0_wdata   = $urandom;
        r1_wdata   = $urandom;
        r0_we      = 1'($urandom);
        r1_we      = 1'($urandom);
        data_valid = 1'b0;
    endtask

    // Requester inputs are garbage while the bus is owned; the DUT must ignore them
    task automatic scramble();
        set_req(1'($urandom), 1'($urandom));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_rv"},    64'(req_valid), 64'd0);
        chk({tag, "_gnt"},   64'({r1_gnt, r0_gnt}), 64'd0);
        chk({tag, "_done"},  64'({r1_done, r0_done}), 64'd0);
    endtask

    // One idle cycle with no requests; optional stray data_valid must be ignored
    task automatic idle_step(input bit dv);
        next_cycle();
        set_req(1'b0, 1'b0);
        data_valid = dv;
        rdata      = $urandom;
        sample();
        check_quiet("idle");
        chk("idle_rsp_hold", 64'(rsp_rdata), 64'(exp_rsp));
        chk("idle_err_hold", 64'(rsp_err), 64'(exp_err));
    endtask

    // Called at the sampling point of an arbitration cycle with requests driven.
    // lat = BUSY cycle (1-based) in which memory answers; > TIMEOUT means never.
    task automatic transaction(input int lat);
        bit win;
        if (r0_req && r1_req) win = !m_last;
        else                  win = r1_req;
        chk("gnt0", 64'(r0_gnt), 64'(!win));
        chk("gnt1", 64'(r1_gnt), 64'(win));
        chk("arb_busy", 64'(busy), 64'd0);
        chk("arb_rv", 64'(req_valid), 64'd0);
        m_last    = win;
        exp_owner = win;
        exp_addr  = win ? r1_addr  : r0_addr;
        exp_wdata = win ? r1_wdata : r0_wdata;
        exp_we    = win ? r1_we    : r0_we;
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            next_cycle();
            scramble();
            data_valid = (i == lat);
            rdata      = use_forced ? forced_rdata : $urandom;
            sample();
            chk("busy_rv",    64'(req_valid), 64'd1);
            chk("busy_addr",  64'(addr), 64'(exp_addr));
            chk("busy_wdata", 64'(wdata), 64'(exp_wdata));
            chk("busy_we",    64'(we), 64'(exp_we));
            chk("busy_busy",  64'(busy), 64'd1);
            chk("busy_gnt",   64'({r1_gnt, r0_gnt}), 64'd0);
            chk("busy_done",  64'({r1_done, r0_done}), 64'd0);
            if (i == lat) begin
                exp_rsp = exp_we ? '0 : rdata;
                exp_err = 1'b0;
                break;
            end
            if (i == int'(TIMEOUT)) begin
                exp_rsp = '0;
                exp_err = 1'b1;
            end
        end
        next_cycle();
        scramble();
        data_valid = 1'($urandom);
        rdata      = $urandom;
        sample();
        chk("done0",     64'(r0_done), 64'(!exp_owner));
        chk("done1",     64'(r1_done), 64'(exp_owner));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp));
        chk("rsp_err",   64'(rsp_err), 64'(exp_err));
        chk("resp_rv",   64'(req_valid), 64'd0);
        chk("resp_busy", 64'(busy), 64'd1);
        chk("resp_gnt",  64'({r1_gnt, r0_gnt}), 64'd0);
    endtask

    // Drive requests for a fresh arbitration cycle and run the transaction
    task automatic start(input bit q0, input bit q1);
        next_cycle();
        set_req(q0, q1);
        sample();
    endtask

    initial begin
        bit win;
        reset        = 1'b0;
        rdata        = '0;
        use_forced   = 1'b0;
        forced_rdata = '0;
        set_req(1'b0, 1'b0);
        m_last  = 1'b1;
        exp_rsp = '0;
        exp_err = 1'b0;

        // Reset values
        repeat (2) sample();
        check_quiet("rst");
        chk("rst_addr",  64'(addr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_we",    64'(we), 64'd0);
        chk("rst_rsp",   64'(rsp_rdata), 64'd0);
        chk("rst_err",   64'(rsp_err), 64'd0);
        r0_req = 1'b1;
        r1_req = 1'b1;
        #1;
        chk("rst_gnt_gated", 64'({r1_gnt, r0_gnt}), 64'd0);

        // Contention from reset release: expect 0,1,0,1
        next_cycle();
        reset = 1'b1;
        set_req(1'b1, 1'b1);
        sample();
        chk("first_contest_p0", 64'(r0_gnt), 64'd1);
        transaction(2);
        for (int k = 0; k < 3; k++) begin
            start(1'b1, 1'b1);
            transaction(2);
        end

        // Single read of address 3
        next_cycle();
        set_req(1'b1, 1'b0);
        r0_addr      = AW'(3);
        r0_we        = 1'b0;
        use_forced   = 1'b1;
        forced_rdata = 32'hDEADBEEF;
        sample();
        transaction(2);
        use_forced = 1'b0;
        chk("read_deadbeef", 64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);
        idle_step(1'b0);

        // Write on port 1
        next_cycle();
        set_req(1'b0, 1'b1);
        r1_we    = 1'b1;
        r1_addr  = AW'(5);
        r1_wdata = 32'h12345678;
        sample();
        transaction(3);
        idle_step(1'b0);

        // Timeout, then a late data_valid in IDLE
        next_cycle();
        set_req(1'b1, 1'b0);
        r0_we = 1'b0;
        sample();
        transaction(int'(TIMEOUT) + 5);
        idle_step(1'b1);
        idle_step(1'b0);

        // data_valid on the final BUSY cycle wins over the timeout
        next_cycle();
        set_req(1'b0, 1'b1);
        r1_we = 1'b0;
        sample();
        transaction(int'(TIMEOUT));
        idle_step(1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit q0, q1;
            q0 = 1'($urandom);
            q1 = 1'($urandom);
            start(q0, q1);
            if (q0 || q1) transaction(int'($urandom_range(2, TIMEOUT + 2)));
            else          check_quiet("rand_idle");
        end

        // Reset in the middle of a transaction
        start(1'b1, 1'b1);
        if (r0_req && r1_req) win = !m_last;
        else                  win = r1_req;
        chk("abort_gnt1", 64'(r1_gnt), 64'(win));
        m_last = win;
        next_cycle();
        sample();
        chk("abort_rv_pre", 64'(req_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_quiet("abort");
        exp_rsp = '0;
        exp_err = 1'b0;
        chk("abort_rsp", 64'(rsp_rdata), 64'd0);
        next_cycle();
        sample();
        check_quiet("abort_hold");
        next_cycle();
        reset  = 1'b1;
        m_last = 1'b1;
        set_req(1'b1, 1'b1);
        sample();
        chk("post_reset_p0", 64'(r0_gnt), 64'd1);
        transaction(2);
        idle_step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
